// File: rtl/cic_integrator_decim.sv
// Integrator-and-decimate half of the receiver CIC decimator: STAGES cascaded integrators, one output every R strobes.
// Optional build macro CIC_DECIM_VARIABLE_EN adds a runtime decimation rate port (i_decim_rate).
module cic_integrator_decim #(
  parameter int STAGES     = 3,
  parameter int DECIMATION = 16,
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 28
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_in_strobe,
  input  logic signed [IN_WIDTH-1:0]  i_in_data,
`ifdef CIC_DECIM_VARIABLE_EN
  input  logic        [15:0]          i_decim_rate,
`endif
  output logic                        o_out_strobe,
  output logic signed [ACC_WIDTH-1:0] o_out_data
);

  localparam logic [15:0] C_DECIM = 16'(DECIMATION);

  logic signed [ACC_WIDTH-1:0] r_acc [STAGES];
  logic        [15:0]          r_cnt;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic                        r_out_strobe;

  logic signed [ACC_WIDTH-1:0] w_in_ext;
  logic                        w_last;

  assign w_in_ext = ACC_WIDTH'(i_in_data);

`ifdef CIC_DECIM_VARIABLE_EN
  // Active rate only changes at a frame boundary so a frame is never truncated.
  logic [15:0] r_rate;
  logic [15:0] w_next_rate;

  assign w_next_rate = (i_decim_rate == 16'd0) ? 16'd1 : i_decim_rate;
  assign w_last      = (r_cnt == r_rate - 16'd1);
`else
  assign w_last      = (r_cnt == C_DECIM - 16'd1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every integrator reads its neighbour's pre-update value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) r_acc[k] <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_strobe <= 1'b0;
`ifdef CIC_DECIM_VARIABLE_EN
      r_rate       <= C_DECIM;
`endif
    end else begin
      r_out_strobe <= 1'b0;
      if (i_in_strobe) begin
        // Modular wrap at ACC_WIDTH is intentional; the downstream combs cancel it.
        r_acc[0] <= r_acc[0] + w_in_ext;
        for (int k = 1; k < STAGES; k++) r_acc[k] <= r_acc[k] + r_acc[k-1];
        if (w_last) begin
          r_cnt        <= '0;
          r_out_data   <= r_acc[STAGES-1];
          r_out_strobe <= 1'b1;
`ifdef CIC_DECIM_VARIABLE_EN
          r_rate       <= w_next_rate;
`endif
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign o_out_strobe = r_out_strobe;
  assign o_out_data   = r_out_data;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// Directed bench for cic_integrator_decim: several small configurations share one stimulus bus.
module tb_cic_integrator_decim;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_strobe = 1'b0;
  logic signed [7:0] in_data = '0;

  always #5 clock = ~clock;

  logic              s1, s2, s3;
  logic signed [13:0] d1, d2;
  logic signed [9:0]  d3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // One integrator, R=4, 14-bit accumulator
  cic_integrator_decim #(.STAGES(1), .DECIMATION(4), .IN_WIDTH(8), .ACC_WIDTH(14)) u_s1 (
    .clock(clock), .reset(reset), .i_in_strobe(in_strobe), .i_in_data(in_data),
`ifdef CIC_DECIM_VARIABLE_EN
    .i_decim_rate(16'd4),
`endif
    .o_out_strobe(s1), .o_out_data(d1));

  // Two integrators, R=4
  cic_integrator_decim #(.STAGES(2), .DECIMATION(4), .IN_WIDTH(8), .ACC_WIDTH(14)) u_s2 (
    .clock(clock), .reset(reset), .i_in_strobe(in_strobe), .i_in_data(in_data),
`ifdef CIC_DECIM_VARIABLE_EN
    .i_decim_rate(16'd4),
`endif
    .o_out_strobe(s2), .o_out_data(d2));

  // One integrator, narrow 10-bit accumulator to exercise the wrap
  cic_integrator_decim #(.STAGES(1), .DECIMATION(4), .IN_WIDTH(8), .ACC_WIDTH(10)) u_wrap (
    .clock(clock), .reset(reset), .i_in_strobe(in_strobe), .i_in_data(in_data),
`ifdef CIC_DECIM_VARIABLE_EN
    .i_decim_rate(16'd4),
`endif
    .o_out_strobe(s3), .o_out_data(d3));

`ifdef CIC_DECIM_VARIABLE_EN
  logic [15:0]        rate = 16'd4;
  logic               sv;
  logic signed [13:0] dv;

  cic_integrator_decim #(.STAGES(1), .DECIMATION(4), .IN_WIDTH(8), .ACC_WIDTH(14)) u_var (
    .clock(clock), .reset(reset), .i_in_strobe(in_strobe), .i_in_data(in_data),
    .i_decim_rate(rate), .o_out_strobe(sv), .o_out_data(dv));
`endif

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic stb, input logic signed [7:0] d);
    @(negedge clock);
    reset     = rst;
    in_strobe = stb;
    in_data   = d;
    @(posedge clock);
    #1;
    cyc_no++;
  endtask

  initial begin
    int exp1, exp2, prev_pulse;

    // Reset state
    cyc(1'b1, 1'b0, 8'sd0);
    cyc(1'b1, 1'b0, 8'sd0);
    check("rst_s1", s1, 0);
    check("rst_d1", d1, 0);
    check("rst_s2", s2, 0);
    check("rst_d2", d2, 0);
    check("rst_s3", s3, 0);
    check("rst_d3", d3, 0);

    // Continuous unit input: 1 stage gives 3,7; 2 stages give (n-1)(n-2)/2 = 3,21
    exp1 = 0;
    exp2 = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc(1'b0, 1'b1, 8'sd1);
      if (n % 4 == 0) begin
        exp1 = n - 1;
        exp2 = (n - 1) * (n - 2) / 2;
      end
      check($sformatf("cont_s1_n%0d", n), s1, (n % 4 == 0));
      check($sformatf("cont_d1_n%0d", n), d1, exp1);
      check($sformatf("cont_s2_n%0d", n), s2, (n % 4 == 0));
      check($sformatf("cont_d2_n%0d", n), d2, exp2);
    end

    // Modular wrap at 10 bits: 3*127=381, 7*127=889 -> -135
    cyc(1'b1, 1'b0, 8'sd0);
    for (int n = 1; n <= 8; n++) begin
      cyc(1'b0, 1'b1, 8'sd127);
      check($sformatf("wrap_s3_n%0d", n), s3, (n % 4 == 0));
      if (n == 4) check("wrap_d3_first", d3, 381);
      if (n == 8) check("wrap_d3_second", d3, -135);
    end

    // Strobe every third cycle: same values, pulses 12 cycles apart, state held in gaps
    cyc(1'b1, 1'b0, 8'sd0);
    exp1 = 0;
    prev_pulse = -1;
    for (int n = 1; n <= 8; n++) begin
      cyc(1'b0, 1'b1, 8'sd1);
      if (n % 4 == 0) exp1 = n - 1;
      check($sformatf("gap_s1_n%0d", n), s1, (n % 4 == 0));
      check($sformatf("gap_d1_n%0d", n), d1, exp1);
      if (s1 === 1'b1) begin
        if (prev_pulse >= 0) check("gap_spacing", cyc_no - prev_pulse, 12);
        prev_pulse = cyc_no;
      end
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 1'b0, 8'sd5);
        check($sformatf("gap_idle_s1_n%0d", n), s1, 0);
        check($sformatf("gap_idle_d1_n%0d", n), d1, exp1);
      end
    end

    // Reset mid-frame together with a strobe: partial frame and that sample discarded
    cyc(1'b0, 1'b1, 8'sd1);
    cyc(1'b0, 1'b1, 8'sd1);
    check("midrst_pre_d1", d1, 7);
    cyc(1'b1, 1'b1, 8'sd1);
    check("midrst_s1", s1, 0);
    check("midrst_d1", d1, 0);
    for (int n = 1; n <= 4; n++) begin
      cyc(1'b0, 1'b1, 8'sd1);
      check($sformatf("midrst_post_s1_n%0d", n), s1, (n == 4));
    end
    check("midrst_post_d1", d1, 3);

`ifdef CIC_DECIM_VARIABLE_EN
    // Runtime rate: 4 -> 2 mid-frame takes effect at the boundary; 0 behaves as 1
    rate = 16'd4;
    cyc(1'b1, 1'b0, 8'sd0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) rate = 16'd2;
      if (k == 7) rate = 16'd0;
      cyc(1'b0, 1'b1, 8'sd1);
      check($sformatf("var_sv_k%0d", k), sv, (k == 4 || k == 6 || k == 8 || k == 9 || k == 10));
      if (sv === 1'b1) check($sformatf("var_dv_k%0d", k), dv, k - 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_integrator_decim.md
# cic_integrator_decim

Integrator-and-decimate front half of the receiver CIC decimation filter. Runs STAGES cascaded integrators at the input sample rate, counts input strobes, and every R-th strobe emits the final integrator value with a one-cycle strobe. The output pair (out_strobe, out_data) drives the strobe and data inputs of the first comb stage in the downstream comb chain at the decimated rate.

## Interface
- STAGES, 3, number of cascaded integrators (1..8)
- DECIMATION, 16, fixed decimation ratio R (≥1); upper bound and reset value for the runtime rate when CIC_DECIM_VARIABLE_EN is defined
- IN_WIDTH, 16, signed input sample width
- ACC_WIDTH, 28, accumulator/output width; the integrator shall require ACC_WIDTH ≥ IN_WIDTH + STAGES·ceil(log2(DECIMATION))
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- in_strobe  in  1  input sample valid, one-cycle qualifier
- in_data  in  IN_WIDTH  signed input sample
- decim_rate  in  16  runtime R; present only with CIC_DECIM_VARIABLE_EN
- out_strobe  out  1  one-cycle pulse, decimated sample valid
- out_data  out  ACC_WIDTH  signed decimated sample; held between strobes

## Operation
- Registers: acc[0..STAGES-1] (ACC_WIDTH, signed), cnt (16 bits), out_data, out_strobe.
- Reset (synchronous) takes priority over everything: all acc = 0, cnt = 0, out_data = 0, out_strobe = 0. Reset asserted mid-frame discards the partial frame; the first post-reset output comes after a full R strobes.
- On in_strobe: acc[0] <= acc[0] + sign_extend(in_data); acc[k] <= acc[k] + acc[k-1] for k ≥ 1, using pre-update values (pipelined cascade).
- Arithmetic is modular two's-complement at ACC_WIDTH; no saturation, no overflow flag. Wrap-around is required for correct CIC operation once the combs are applied downstream.
- Decimation counter: increments on each in_strobe; when cnt = R-1 and in_strobe, cnt <= 0, out_data <= acc[STAGES-1] (pre-update value), out_strobe <= 1.
- No in_strobe: all state holds; out_strobe <= 0.
- out_data changes only on a decimating strobe or reset.

## Timing
- out_strobe rises the clock after the decimating in_strobe and lasts exactly one cycle.
- Input-to-output latency: an impulse at in_strobe n first reaches acc[STAGES-1] after STAGES strobes; capture of the pre-update value adds one more strobe.
- Back-to-back in_strobe every cycle is supported; with R = 1, out_strobe is high on every cycle following a strobe.
- Gaps between in_strobes do not affect counting. Only strobes are counted.
- Reset and in_strobe in the same cycle: reset wins and the sample is dropped.

## Configuration
- CIC_DECIM_VARIABLE_EN defined: R = decim_rate. The rate is sampled into an internal register at reset (loaded with DECIMATION) and at each counter wrap. A new value therefore takes effect at the next frame boundary and never truncates the current frame. decim_rate of 0 is treated as 1. Values above DECIMATION give unspecified bit growth; setting them is the caller's responsibility.
- Not defined: R = DECIMATION as a constant. The decim_rate port does not exist, and the counter compare reduces to a constant.

## Test plan
- STAGES=1, R=4, IN_WIDTH=8, ACC_WIDTH=14, in_data=1 on every cycle -> out_data 3, 7, 11, …; out_strobe pulses exactly once per 4 strobes.
- STAGES=2, R=4, in_data=1 continuous -> first two outputs 3, then 21. This is (n-1)(n-2)/2 at n=4 and n=8.
- STAGES=1, R=4, IN_WIDTH=8, ACC_WIDTH=10, in_data=127 continuous -> out_data 381, then -135. This checks the modular wrap.
- Strobe every 3rd cycle, STAGES=1, R=4, in_data=1 -> same values as the first test; out_strobe is one cycle wide and spaced 12 cycles apart; the state holds between strobes.
- Reset asserted after 2 strobes of a frame, together with an in_strobe -> outputs 0; that sample is ignored; the next out_strobe comes after 4 further strobes, with out_data 3.
- With CIC_DECIM_VARIABLE_EN, R changed from 4 to 2 mid-frame -> the current frame completes at 4 strobes; subsequent out_strobes come every 2 strobes. decim_rate=0 -> out_strobe follows every in_strobe.
